// File: rtl/cpu_xfer_ctrl_if.sv
// Signal bundle between the CPU bus front-end, the transfer sequencer and the memory port.
// The sequencer connects through the slave modport.
interface cpu_xfer_ctrl_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned LW = 3
);
   localparam int unsigned NB = DW / 8;

   logic          cmd_valid;
   logic          cmd_ready;
   logic [31:0]   cmd_addr;
   logic [1:0]    cmd_siz;
   logic [1:0]    cmd_tt;
   logic          cmd_we;
   logic          req_valid;
   logic          req_ready;
   logic [31:0]   req_addr;
   logic [LW-1:0] req_len;
   logic [NB-1:0] req_mask;
   logic          req_we;
   logic          req_wrap;
   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          write_valid;
   logic [DW-1:0] write_data;
   logic          read_valid;
   logic [DW-1:0] read_data;
   logic          read_ack;
   logic          beat_valid;
   logic [DW-1:0] beat_data;
   logic          beat_ack;
   logic          irq_req;
   logic [7:0]    irq_vec;
   logic          irq_ack;
   logic          busy;

   modport slave (
      input  cmd_valid, cmd_addr, cmd_siz, cmd_tt, cmd_we, req_ready, wr_valid, wr_data,
             read_valid, read_data, beat_ack, irq_req, irq_vec,
      output cmd_ready, req_valid, req_addr, req_len, req_mask, req_we, req_wrap, wr_ready,
             write_valid, write_data, read_ack, beat_valid, beat_data, irq_ack, busy
   );

   modport master (
      output cmd_valid, cmd_addr, cmd_siz, cmd_tt, cmd_we, req_ready, wr_valid, wr_data,
             read_valid, read_data, beat_ack, irq_req, irq_vec,
      input  cmd_ready, req_valid, req_addr, req_len, req_mask, req_we, req_wrap, wr_ready,
             write_valid, write_data, read_ack, beat_valid, beat_data, irq_ack, busy
   );
endinterface

// File: rtl/cpu_xfer_ctrl.sv
// Transfer sequencer: turns one decoded CPU bus cycle into a memory request, buffers read beats
// in a small FIFO, forwards write beats and services int-ack and alternate-space cycles.
module cpu_xfer_ctrl #(
   parameter int unsigned DW           = 32,
   parameter int unsigned LW           = 3,
   parameter int unsigned LINE_BYTES   = 16,
   parameter logic [15:0] ROM_OFF      = 16'hF000,
   parameter int unsigned ROM_BOOT_CNT = 2,
   parameter int unsigned RD_DEPTH     = 4
) (
   input logic            clk_i,
   input logic            rst_ni,
   cpu_xfer_ctrl_if.slave bus
);
   localparam int unsigned   NB     = DW / 8;
   localparam int unsigned   NBW    = $clog2(NB);
   localparam int unsigned   LB     = LINE_BYTES / NB;
   localparam int unsigned   AW     = $clog2(RD_DEPTH);
   localparam int unsigned   BCW    = (ROM_BOOT_CNT > 0) ? $clog2(ROM_BOOT_CNT + 1) : 1;
   localparam logic [NB-1:0] MASK_W = {NB{1'b1}} << (NB - 2);
   localparam logic [NB-1:0] MASK_L = {NB{1'b1}} << (NB - 4);

   typedef enum logic [2:0] {StIdle, StReq, StRd, StWr, StIack, StIvec, StAlt} state_e;

   state_e         r_state, w_state_d;
   logic           r_rdy_en;
   logic           r_req_valid, w_req_valid_d;
   logic [31:0]    r_req_addr, w_req_addr_d;
   logic [LW-1:0]  r_req_len, w_req_len_d;
   logic [NB-1:0]  r_req_mask, w_req_mask_d;
   logic           r_req_we, w_req_we_d;
   logic [BCW-1:0] r_boot_cnt, w_boot_cnt_d;
   logic           r_irq_ack, w_irq_ack_d;
   logic [7:0]     r_vec, w_vec_d;
   logic [LW-1:0]  r_pushed, w_pushed_d;
   logic [LW-1:0]  r_done, w_done_d;  // beats popped (read) or taken (write)
   logic           r_write_valid;
   logic [DW-1:0]  r_write_data;
   logic [DW-1:0]  r_fifo [RD_DEPTH];
   logic [AW:0]    r_wptr, r_rptr;

   logic           w_cmd_ready, w_cmd_fire, w_empty, w_full, w_push, w_pop, w_wr_fire;
   logic [NB-1:0]  w_mask;
   logic [LW-1:0]  w_len;
   logic [DW-1:0]  w_beat_data;

   assign w_cmd_ready = r_rdy_en && (r_state == StIdle);
   assign w_cmd_fire  = w_cmd_ready && bus.cmd_valid;
   assign w_empty     = (r_wptr == r_rptr);
   assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   // Never accept more read beats than the request asked for.
   assign w_push      = (r_state == StRd) && bus.read_valid && !w_full && (r_pushed != r_req_len);
   assign w_pop       = (r_state == StRd) && bus.beat_ack && !w_empty;
   assign w_wr_fire   = (r_state == StWr) && bus.wr_valid;

   always_comb begin : mask_decode
      w_mask = '0;
      w_len  = LW'(1);
      unique case (bus.cmd_siz)
         2'b01:   w_mask[NBW'(NB - 1) - bus.cmd_addr[NBW-1:0]] = 1'b1;
         2'b10:   w_mask = MASK_W >> {bus.cmd_addr[NBW-1:1], 1'b0};
         2'b00:   w_mask = (NB == 4) ? {NB{1'b1}} : (MASK_L >> {bus.cmd_addr[2], 2'b00});
         default: begin
            w_mask = {NB{1'b1}};
            w_len  = LW'(LB);
         end
      endcase
   end

   always_comb begin : fsm_next
      w_state_d     = r_state;
      w_req_valid_d = r_req_valid;
      w_req_addr_d  = r_req_addr;
      w_req_len_d   = r_req_len;
      w_req_mask_d  = r_req_mask;
      w_req_we_d    = r_req_we;
      w_boot_cnt_d  = r_boot_cnt;
      w_irq_ack_d   = r_irq_ack;
      w_vec_d       = r_vec;
      w_pushed_d    = r_pushed;
      w_done_d      = r_done;
      unique case (r_state)
         StIdle: begin
            if (w_cmd_fire) begin
               unique case (bus.cmd_tt)
                  2'b11: begin
                     w_irq_ack_d = 1'b1;
                     w_state_d   = StIack;
                  end
                  2'b10:   w_state_d = StAlt;
                  default: begin
                     w_req_valid_d = 1'b1;
                     w_req_addr_d  = bus.cmd_addr;
                     w_req_len_d   = w_len;
                     w_req_mask_d  = w_mask;
                     w_req_we_d    = bus.cmd_we;
                     w_state_d     = StReq;
                     if (r_boot_cnt < BCW'(ROM_BOOT_CNT)) begin
                        w_req_addr_d = {ROM_OFF, bus.cmd_addr[15:0]};
                        w_boot_cnt_d = r_boot_cnt + BCW'(1);
                     end
                  end
               endcase
            end
         end
         StReq: begin
            if (bus.req_ready) begin
               w_req_valid_d = 1'b0;
               w_pushed_d    = '0;
               w_done_d      = '0;
               w_state_d     = r_req_we ? StWr : StRd;
            end
         end
         StRd: begin
            if (w_push) w_pushed_d = r_pushed + LW'(1);
            if (w_pop) begin
               w_done_d = r_done + LW'(1);
               if (r_done + LW'(1) == r_req_len) w_state_d = StIdle;
            end
         end
         StWr: begin
            if (w_wr_fire) begin
               w_done_d = r_done + LW'(1);
               if (r_done + LW'(1) == r_req_len) w_state_d = StIdle;
            end
         end
         StIack: begin
            if (bus.irq_req) begin
               w_irq_ack_d = 1'b0;
               w_vec_d     = bus.irq_vec;
               w_state_d   = StIvec;
            end
         end
         default: begin
            if (bus.beat_ack) w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= StIdle;
         r_rdy_en      <= 1'b0;
         r_req_valid   <= 1'b0;
         r_req_addr    <= '0;
         r_req_len     <= '0;
         r_req_mask    <= '0;
         r_req_we      <= 1'b0;
         r_boot_cnt    <= '0;
         r_irq_ack     <= 1'b0;
         r_vec         <= '0;
         r_pushed      <= '0;
         r_done        <= '0;
         r_write_valid <= 1'b0;
         r_write_data  <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
      end else begin
         r_state       <= w_state_d;
         r_rdy_en      <= 1'b1;
         r_req_valid   <= w_req_valid_d;
         r_req_addr    <= w_req_addr_d;
         r_req_len     <= w_req_len_d;
         r_req_mask    <= w_req_mask_d;
         r_req_we      <= w_req_we_d;
         r_boot_cnt    <= w_boot_cnt_d;
         r_irq_ack     <= w_irq_ack_d;
         r_vec         <= w_vec_d;
         r_pushed      <= w_pushed_d;
         r_done        <= w_done_d;
         r_write_valid <= w_wr_fire;
         if (w_wr_fire) r_write_data <= bus.wr_data;
         if (w_push) r_wptr <= r_wptr + (AW + 1)'(1);
         if (w_pop) r_rptr <= r_rptr + (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_fifo[r_wptr[AW-1:0]] <= bus.read_data;
   end

   always_comb begin : beat_mux
      w_beat_data = '0;
      if (r_state == StRd) w_beat_data = r_fifo[r_rptr[AW-1:0]];
      else if (r_state == StIvec) w_beat_data = DW'(r_vec);
   end

   assign bus.cmd_ready   = w_cmd_ready;
   assign bus.req_valid   = r_req_valid;
   assign bus.req_addr    = r_req_addr;
   assign bus.req_len     = r_req_len;
   assign bus.req_mask    = r_req_mask;
   assign bus.req_we      = r_req_we;
   assign bus.req_wrap    = 1'b1;
   assign bus.wr_ready    = (r_state == StWr);
   assign bus.write_valid = r_write_valid;
   assign bus.write_data  = r_write_data;
   assign bus.read_ack    = w_push;
   assign bus.beat_valid  = ((r_state == StRd) && !w_empty) || (r_state == StIvec) ||
                            (r_state == StAlt);
   assign bus.beat_data   = w_beat_data;
   assign bus.irq_ack     = r_irq_ack;
   assign bus.busy        = (r_state != StIdle);
endmodule
